crc8_64_err_mon: RTL

Downstream stage of the CRC-8 (72,64) decoder. It registers the decoder's data and error flags, and maintains saturating corrected- and fatal-error counters. It also tracks the corrected-error rate over a fixed cycle window and runs a health state machine (OK / DEGRADED / FAILED) that raises an interrupt pulse. Its outputs feed the datapath consumer and the status/CSR block.

---
 rtl/crc8_64_err_mon_if.sv | 19 +
 rtl/crc8_64_err_mon.sv | 79 +++++++
 2 files changed

// File: rtl/crc8_64_err_mon_if.sv
// crc8_64_err_mon_if: decoder-side input bus and registered datapath output bus
interface crc8_64_err_mon_if;
    logic        i_valid;
    logic [0:63] i_data;
    logic        i_err_corr;
    logic        i_err_detec;
    logic        i_err_fatal;
    logic [0:63] o_data;
    logic        o_valid;
    logic        o_poison;
    modport master (
        output i_valid, i_data, i_err_corr, i_err_detec, i_err_fatal,
        input  o_data, o_valid, o_poison
    );
    modport slave (
        input  i_valid, i_data, i_err_corr, i_err_detec, i_err_fatal,
        output o_data, o_valid, o_poison
    );
endinterface

// File: rtl/crc8_64_err_mon.sv
// crc8_64_err_mon: registers CRC-8 (72,64) decoder output, counts corrected/fatal events,
// tracks the corrected-error rate per window and runs the OK/DEGRADED/FAILED health FSM.
module crc8_64_err_mon #(
    parameter int CNT_W       = 16,
    parameter int WIN_LEN     = 1024,
    parameter int CORR_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    crc8_64_err_mon_if.slave     bus,
    input  logic                 i_clr,
    output logic [CNT_W-1:0]     o_corr_cnt,
    output logic [CNT_W-1:0]     o_fatal_cnt,
    output logic [1:0]           o_state,
    output logic                 o_irq
);
    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int WC_W  = $clog2(CORR_THRESH + 2);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [WC_W-1:0]  THRESH   = WC_W'(CORR_THRESH);
    typedef enum logic [1:0] {ST_OK = 2'd0, ST_DEG = 2'd1, ST_FAIL = 2'd2} state_t;
    state_t           state;
    logic [WIN_W-1:0] win_cnt;
    logic [WC_W-1:0]  win_corr;
    logic [WC_W-1:0]  win_res;
    logic             corr_ev;
    logic             fatal_ev;
    logic             wrap;
    assign corr_ev  = bus.i_valid & bus.i_err_corr & ~bus.i_err_fatal;
    assign fatal_ev = bus.i_valid & (bus.i_err_fatal | (bus.i_err_detec & ~bus.i_err_corr));
    assign wrap     = win_cnt == WIN_LAST;
    // win_corr saturates at THRESH, so THRESH+1 always fits in WC_W bits
    assign win_res  = win_corr + WC_W'(corr_ev);
    assign o_state  = state;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.o_data   <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_poison <= 1'b0;
        end else begin
            bus.o_valid  <= bus.i_valid;
            bus.o_poison <= fatal_ev;
            if (bus.i_valid) bus.o_data <= bus.i_data;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_corr_cnt  <= '0;
            o_fatal_cnt <= '0;
            win_cnt     <= '0;
            win_corr    <= '0;
            state       <= ST_OK;
            o_irq       <= 1'b0;
        end else if (i_clr) begin
            o_corr_cnt  <= '0;
            o_fatal_cnt <= '0;
            win_cnt     <= '0;
            win_corr    <= '0;
            state       <= ST_OK;
            o_irq       <= 1'b0;
        end else begin
            if (corr_ev && o_corr_cnt != '1) o_corr_cnt <= o_corr_cnt + 1'b1;
            if (fatal_ev && o_fatal_cnt != '1) o_fatal_cnt <= o_fatal_cnt + 1'b1;
            win_cnt  <= wrap ? '0 : win_cnt + 1'b1;
            win_corr <= wrap ? '0 : (corr_ev && win_corr != THRESH) ? win_corr + 1'b1 : win_corr;
            o_irq    <= 1'b0;
            // fatal outranks the window decision made on the same cycle
            if (state != ST_FAIL && fatal_ev) begin
                state <= ST_FAIL;
                o_irq <= 1'b1;
            end else if (state == ST_OK && wrap && win_res >= THRESH) begin
                state <= ST_DEG;
                o_irq <= 1'b1;
            end else if (state == ST_DEG && wrap && win_res == '0) begin
                state <= ST_OK;
            end
        end
    end
endmodule
